// File: rtl/mem_alloc_pkg.sv
// rtl/mem_alloc_pkg.sv - widths, state/source encodings and IO base shared by the allocator
package mem_alloc_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic        TRUE  = 1'b1;
    localparam logic        FALSE = 1'b0;
    localparam logic [31:0] ZERO  = 32'h0000_0000;

    // Byte addresses at or above this belong to the UART/IO window
    localparam logic [ADDR_W-1:0] IO_BASE = 32'h0003_0000;

    typedef enum logic [1:0] {
        ALLOC_IDLE  = 2'd0,
        ALLOC_READ  = 2'd1,
        ALLOC_WRITE = 2'd2
    } alloc_state_e;

    typedef enum logic {
        SRC_IF  = 1'b0,
        SRC_LSB = 1'b1
    } alloc_src_e;

endpackage

// File: rtl/mem_byte_pack.sv
// rtl/mem_byte_pack.sv - byte lane extract for writes, lane insert with zero-fill for reads
module mem_byte_pack (
    input  logic [31:0] wr_word,
    input  logic [1:0]  wr_lane,
    output logic [7:0]  wr_byte,
    input  logic [31:0] rd_word,
    input  logic [1:0]  rd_lane,
    input  logic [7:0]  rd_byte,
    input  logic [1:0]  rd_cnt,
    output logic [31:0] rd_packed
);

    always_comb begin
        wr_byte   = wr_word[{wr_lane, 3'b000} +: 8];
        rd_packed = rd_word;
        rd_packed[{rd_lane, 3'b000} +: 8] = rd_byte;
        // Lanes beyond the requested byte count always read as zero
        for (int i = 0; i < 4; i++) begin
            if (i > int'(rd_cnt)) begin
                rd_packed[8*i +: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/mem_alloc.sv
// rtl/mem_alloc.sv - byte-serial RAM allocator for IF fetches and LSB loads/stores; IO_STALL_EN adds UART-full write stalls
import mem_alloc_pkg::*;

module mem_alloc #(
    parameter int AddrWidth = ADDR_W,
    parameter int DataWidth = DATA_W
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 if_to_alloc_en_in,
    input  logic [AddrWidth-1:0] if_a_in,
    input  logic [1:0]           if_offset_in,
    output logic                 alloc_to_if_gr_out,
    output logic                 alloc_to_if_en_out,
    output logic [DataWidth-1:0] if_d_out,
    input  logic                 lsb_to_alloc_en_in,
    input  logic                 lsb_wr_in,
    input  logic [AddrWidth-1:0] lsb_a_in,
    input  logic [1:0]           lsb_offset_in,
    input  logic [DataWidth-1:0] lsb_d_in,
    output logic                 alloc_to_lsb_gr_out,
    output logic                 alloc_to_lsb_en_out,
    output logic [DataWidth-1:0] lsb_d_out,
    input  logic                 clear_branch_in,
    input  logic                 io_buffer_full_in,
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [AddrWidth-1:0] mem_a,
    output logic                 mem_wr
);

    alloc_state_e         state_q, state_d;
    alloc_src_e           src_q, src_d, last_q, last_d;
    logic [AddrWidth-1:0] base_q, base_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [DataWidth-1:0] rbuf_q, rbuf_d;
    logic [2:0]           step_q, step_d;
    logic [AddrWidth-1:0] a_d;
    logic [7:0]           dout_d;
    logic                 wr_d;
    logic                 if_gr_d, lsb_gr_d, if_en_d, lsb_en_d;
    logic [DataWidth-1:0] if_d_d, lsb_d_d;

    logic                 if_req, lsb_req, take_lsb, acc_write, io_stall;
    logic [AddrWidth-1:0] acc_a, step_a, wr_a;
    logic [1:0]           acc_cnt;
    logic [7:0]           wr_byte;
    logic [DataWidth-1:0] rd_packed;
    logic [DataWidth-1:0] pack_wr_word;
    logic [1:0]           pack_wr_lane;

    // A flush only suppresses IF acceptance; LSB traffic is unaffected
    assign if_req    = if_to_alloc_en_in && !clear_branch_in;
    assign lsb_req   = lsb_to_alloc_en_in;
    assign take_lsb  = lsb_req && (!if_req || last_q == SRC_IF);
    assign acc_a     = take_lsb ? lsb_a_in : if_a_in;
    assign acc_cnt   = take_lsb ? lsb_offset_in : if_offset_in;
    assign acc_write = take_lsb && lsb_wr_in;
    assign step_a    = base_q + AddrWidth'(step_q);
    assign wr_a      = (state_q == ALLOC_IDLE) ? acc_a : step_a;

`ifdef IO_STALL_EN
    assign io_stall = io_buffer_full_in && (wr_a >= IO_BASE);
`else
    logic unused_io;
    assign unused_io = io_buffer_full_in ^ wr_a[0];
    assign io_stall  = FALSE;
`endif

    assign pack_wr_word = (state_q == ALLOC_IDLE) ? lsb_d_in : wdata_q;
    assign pack_wr_lane = (state_q == ALLOC_IDLE) ? 2'd0 : step_q[1:0];

    // Read lane lags the step by two: one edge of RAM latency, one of sampling
    mem_byte_pack u_pack (
        .wr_word   (pack_wr_word),
        .wr_lane   (pack_wr_lane),
        .wr_byte   (wr_byte),
        .rd_word   (rbuf_q),
        .rd_lane   (step_q[1:0] - 2'd2),
        .rd_byte   (mem_din),
        .rd_cnt    (cnt_q),
        .rd_packed (rd_packed)
    );

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        last_d   = last_q;
        base_d   = base_q;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        rbuf_d   = rbuf_q;
        step_d   = step_q;
        a_d      = mem_a;
        dout_d   = mem_dout;
        wr_d     = FALSE;
        if_gr_d  = FALSE;
        lsb_gr_d = FALSE;
        if_en_d  = FALSE;
        lsb_en_d = FALSE;
        if_d_d   = if_d_out;
        lsb_d_d  = lsb_d_out;

        unique case (state_q)
            ALLOC_IDLE: begin
                if (if_req || lsb_req) begin
                    src_d    = take_lsb ? SRC_LSB : SRC_IF;
                    last_d   = take_lsb ? SRC_LSB : SRC_IF;
                    base_d   = acc_a;
                    cnt_d    = acc_cnt;
                    wdata_d  = lsb_d_in;
                    rbuf_d   = ZERO;
                    if_gr_d  = !take_lsb;
                    lsb_gr_d = take_lsb;
                    a_d      = acc_a;
                    step_d   = 3'd1;
                    if (acc_write) begin
                        state_d = ALLOC_WRITE;
                        if (io_stall) begin
                            step_d = 3'd0;
                        end else begin
                            wr_d   = TRUE;
                            dout_d = wr_byte;
                        end
                    end else begin
                        state_d = ALLOC_READ;
                    end
                end
            end
            ALLOC_READ: begin
                step_d = step_q + 3'd1;
                if (step_q <= {1'b0, cnt_q}) begin
                    a_d = step_a;
                end
                if (step_q >= 3'd2) begin
                    rbuf_d = rd_packed;
                end
                if (step_q == {1'b0, cnt_q} + 3'd2) begin
                    state_d = ALLOC_IDLE;
                    if (src_q == SRC_IF) begin
                        if_en_d = TRUE;
                        if_d_d  = rd_packed;
                    end else begin
                        lsb_en_d = TRUE;
                        lsb_d_d  = rd_packed;
                    end
                end
            end
            ALLOC_WRITE: begin
                if (step_q <= {1'b0, cnt_q}) begin
                    a_d = step_a;
                    if (!io_stall) begin
                        wr_d   = TRUE;
                        dout_d = wr_byte;
                        step_d = step_q + 3'd1;
                    end
                end else begin
                    state_d  = ALLOC_IDLE;
                    lsb_en_d = TRUE;
                end
            end
            default: state_d = ALLOC_IDLE;
        endcase
    end

    // rdy_in low freezes everything, so pending pulses simply persist
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q             <= ALLOC_IDLE;
            src_q               <= SRC_IF;
            last_q              <= SRC_IF;
            base_q              <= '0;
            cnt_q               <= '0;
            wdata_q             <= '0;
            rbuf_q              <= '0;
            step_q              <= '0;
            mem_a               <= '0;
            mem_dout            <= '0;
            mem_wr              <= FALSE;
            alloc_to_if_gr_out  <= FALSE;
            alloc_to_lsb_gr_out <= FALSE;
            alloc_to_if_en_out  <= FALSE;
            alloc_to_lsb_en_out <= FALSE;
            if_d_out            <= '0;
            lsb_d_out           <= '0;
        end else if (rdy_in) begin
            state_q             <= state_d;
            src_q               <= src_d;
            last_q              <= last_d;
            base_q              <= base_d;
            cnt_q               <= cnt_d;
            wdata_q             <= wdata_d;
            rbuf_q              <= rbuf_d;
            step_q              <= step_d;
            mem_a               <= a_d;
            mem_dout            <= dout_d;
            mem_wr              <= wr_d;
            alloc_to_if_gr_out  <= if_gr_d;
            alloc_to_lsb_gr_out <= lsb_gr_d;
            alloc_to_if_en_out  <= if_en_d;
            alloc_to_lsb_en_out <= lsb_en_d;
            if_d_out            <= if_d_d;
            lsb_d_out           <= lsb_d_d;
        end
    end

endmodule
